elixirchip_es1_spu_op_descrambler: RTL and testbench

- Self-synchronising (multiplicative) descrambler for the ES1 SPU datapath.
- Receiver-side inverse of the XOR-based scrambler op: it removes the LFSR keystream from a scrambled word stream, DATA_BITS bits per valid cycle.
- Sits in an SPU op chain with the same reset/clk/cke/s_clear/s_valid contract as the other spu_op blocks.
- Adds an output valid and a lock flag so downstream logic can ignore words produced before the history register has filled.

---
 rtl/elixirchip_es1_spu_op_descrambler.sv | 91 +++++++++
 tb/tb_elixirchip_es1_spu_op_descrambler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/elixirchip_es1_spu_op_descrambler.sv
// elixirchip_es1_spu_op_descrambler: self-synchronising multiplicative descrambler with valid and lock flags
module elixirchip_es1_spu_op_descrambler #(
    parameter int                   LATENCY    = 1,
    parameter int                   DATA_BITS  = 8,
    parameter int                   POLY_BITS  = 7,
    parameter logic [POLY_BITS-1:0] POLY       = 7'b110_0000,
    parameter logic [POLY_BITS-1:0] INIT_STATE = '0,
    parameter logic [DATA_BITS-1:0] CLEAR_DATA = 'x,
    parameter                       DEVICE     = "RTL",
    parameter                       SIMULATION = "false",
    parameter                       DEBUG      = "false"
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_clear,
    input  logic                 s_valid,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_locked
);
    localparam int FILL_WORDS = (POLY_BITS + DATA_BITS - 1) / DATA_BITS;
    localparam int CW         = $clog2(FILL_WORDS + 1);
    localparam int PW         = DATA_BITS + 2;
    localparam int STAGES     = (LATENCY < 1) ? 1 : LATENCY;

    typedef enum logic {UNSYNC, SYNC} lock_t;

    if (LATENCY < 1) begin : g_latency_check
        $error("elixirchip_es1_spu_op_descrambler: LATENCY must be >= 1");
    end

    logic                 unused_params;
    logic [POLY_BITS-1:0] hist_q, hist_d, hist_shift;
    logic [CW-1:0]        cnt_q, cnt_d;
    lock_t                state_q, state_d;
    logic [DATA_BITS-1:0] desc;
    logic                 adv, clr;
    logic [PW-1:0]        stage_d;
    logic [PW-1:0]        pipe_q [STAGES];

    assign unused_params = ^{DEVICE, SIMULATION, DEBUG};
    assign adv = cke && s_valid && !s_clear;
    assign clr = cke && s_valid && s_clear;

    // Bit-serial descramble of the whole word, oldest bit first; received bits feed the history
    always_comb begin
        hist_shift = hist_q;
        desc = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            desc[i] = s_data[i] ^ (^(hist_shift & POLY));
            hist_shift = (hist_shift << 1) | POLY_BITS'(s_data[i]);
        end
    end

    // History, saturating fill counter and lock FSM next state; all hold unless a word is accepted
    always_comb begin
        hist_d  = clr ? INIT_STATE : adv ? hist_shift : hist_q;
        cnt_d   = clr ? '0 : (adv && cnt_q != CW'(FILL_WORDS)) ? cnt_q + CW'(1) : cnt_q;
        state_d = clr ? UNSYNC : (cnt_d == CW'(FILL_WORDS)) ? SYNC : state_q;
    end

    // Descrambler state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= INIT_STATE;
            cnt_q   <= '0;
            state_q <= UNSYNC;
        end else begin
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // First-stage word: a clear emits CLEAR_DATA unlocked, otherwise lock reflects history before this word
    always_comb stage_d = clr ? {1'b1, 1'b0, CLEAR_DATA} : {s_valid, state_q == SYNC, desc};

    // Output pipeline {valid, locked, data}, LATENCY stages, all frozen while cke is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) pipe_q[k] <= '0;
        end else if (cke) begin
            pipe_q[0] <= stage_d;
            for (int k = 1; k < STAGES; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign {m_valid, m_locked, m_data} = pipe_q[STAGES-1];
endmodule

// File: tb/tb_elixirchip_es1_spu_op_descrambler.sv
// tb_elixirchip_es1_spu_op_descrambler: directed tests of the descrambler at LATENCY 1 and 3
module tb_elixirchip_es1_spu_op_descrambler;
    localparam logic [6:0] POLY = 7'b110_0000;

    logic       clk = 0, reset = 0, cke = 1, s_clear = 0, s_valid = 0;
    logic [7:0] s_data = '0;
    logic [7:0] m_data, m3_data;
    logic       m_valid, m_locked, m3_valid, m3_locked;
    logic [6:0] sc;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_descrambler #(.LATENCY(1), .CLEAR_DATA(8'hA5)) dut (
        .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid), .m_locked(m_locked)
    );

    elixirchip_es1_spu_op_descrambler #(.LATENCY(3)) dut3 (
        .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
        .m_data(m3_data), .m_valid(m3_valid), .m_locked(m3_locked)
    );

    task automatic send(input logic [7:0] d, input logic v, input logic c);
        s_data = d; s_valid = v; s_clear = c;
        @(posedge clk); #1;
        s_valid = 0; s_clear = 0;
    endtask

    task automatic do_reset;
        reset = 1; s_valid = 0; s_clear = 0; cke = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic scr(input logic [7:0] d, output logic [7:0] o);
        for (int i = 0; i < 8; i++) begin
            o[i] = d[i] ^ (^(sc & POLY));
            sc = {sc[5:0], o[i]};
        end
    endtask

    task automatic test_reset;
        reset = 1; cke = 1; s_valid = 0;
        #1;
        checks++; if ({m_valid, m_locked, m_data} !== 10'h000) begin errors++; $display("FAIL reset_async_l1: got %h expected 000", {m_valid, m_locked, m_data}); end
        checks++; if ({m3_valid, m3_locked, m3_data} !== 10'h000) begin errors++; $display("FAIL reset_async_l3: got %h expected 000", {m3_valid, m3_locked, m3_data}); end
        repeat (2) @(posedge clk); #1;
        checks++; if ({m_valid, m_locked, m_data} !== 10'h000) begin errors++; $display("FAIL reset_held_l1: got %h expected 000", {m_valid, m_locked, m_data}); end
        reset = 0;
    endtask

    task automatic test_basic;
        do_reset;
        send(8'h01, 1, 0);
        checks++; if ({m_valid, m_locked, m_data} !== {2'b10, 8'hC1}) begin errors++; $display("FAIL basic_w0: got %h expected %h", {m_valid, m_locked, m_data}, {2'b10, 8'hC1}); end
        send(8'h00, 1, 0);
        checks++; if ({m_valid, m_locked, m_data} !== {2'b11, 8'h00}) begin errors++; $display("FAIL basic_w1: got %h expected %h", {m_valid, m_locked, m_data}, {2'b11, 8'h00}); end
    endtask

    task automatic test_bubble_cke;
        do_reset;
        send(8'h01, 1, 0);
        checks++; if ({m_valid, m_locked, m_data} !== {2'b10, 8'hC1}) begin errors++; $display("FAIL bubble_w0: got %h expected %h", {m_valid, m_locked, m_data}, {2'b10, 8'hC1}); end
        cke = 0; s_data = 8'hFF; s_valid = 1; s_clear = 1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++; if ({m_valid, m_locked, m_data} !== {2'b10, 8'hC1}) begin errors++; $display("FAIL cke_freeze_%0d: got %h expected %h", n, {m_valid, m_locked, m_data}, {2'b10, 8'hC1}); end
        end
        cke = 1; s_valid = 0; s_clear = 0;
        send(8'h00, 0, 0);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b expected 0", m_valid); end
        send(8'h00, 1, 0);
        checks++; if ({m_valid, m_locked, m_data} !== {2'b11, 8'h00}) begin errors++; $display("FAIL bubble_w1: got %h expected %h", {m_valid, m_locked, m_data}, {2'b11, 8'h00}); end
    endtask

    task automatic test_clear;
        do_reset;
        send(8'h01, 1, 0);
        send(8'h00, 1, 0);
        checks++; if ({m_valid, m_locked, m_data} !== {2'b11, 8'h00}) begin errors++; $display("FAIL clear_pre: got %h expected %h", {m_valid, m_locked, m_data}, {2'b11, 8'h00}); end
        send(8'h77, 1, 1);
        checks++; if ({m_valid, m_locked, m_data} !== {2'b10, 8'hA5}) begin errors++; $display("FAIL clear_word: got %h expected %h", {m_valid, m_locked, m_data}, {2'b10, 8'hA5}); end
        send(8'h01, 1, 0);
        checks++; if ({m_valid, m_locked, m_data} !== {2'b10, 8'hC1}) begin errors++; $display("FAIL clear_next: got %h expected %h", {m_valid, m_locked, m_data}, {2'b10, 8'hC1}); end
        send(8'h00, 1, 0);
        checks++; if ({m_valid, m_locked, m_data} !== {2'b11, 8'h00}) begin errors++; $display("FAIL clear_relock: got %h expected %h", {m_valid, m_locked, m_data}, {2'b11, 8'h00}); end
    endtask

    task automatic test_round_trip;
        logic [7:0] d, o;
        int locked_words;
        locked_words = 0;
        do_reset;
        sc = 7'h5A;
        for (int n = 0; n < 1000; n++) begin
            d = 8'($urandom);
            scr(d, o);
            send(o, 1, 0);
            if (m_locked) begin
                locked_words++;
                checks++; if (m_data !== d) begin errors++; $display("FAIL round_trip_%0d: got %h expected %h", n, m_data, d); end
            end
        end
        checks++; if (locked_words !== 999) begin errors++; $display("FAIL round_trip_locked: got %0d expected 999", locked_words); end
    endtask

    task automatic test_error_injection;
        logic [7:0] d [4];
        logic [7:0] e [4];
        logic [7:0] o;
        d = '{8'h3C, 8'h96, 8'h5A, 8'hF0};
        e = '{8'h00, 8'h08, 8'h06, 8'h00};
        for (int n = 0; n < 4; n++) begin
            scr(d[n], o);
            send(n == 1 ? o ^ 8'h08 : o, 1, 0);
            checks++; if ({m_valid, m_locked, m_data} !== {2'b11, d[n] ^ e[n]}) begin errors++; $display("FAIL error_inj_%0d: got %h expected %h", n, {m_valid, m_locked, m_data}, {2'b11, d[n] ^ e[n]}); end
        end
    endtask

    task automatic test_reset_midstream;
        do_reset;
        send(8'h01, 1, 0);
        checks++; if (m3_valid !== 1'b0) begin errors++; $display("FAIL l3_latency: got %b expected 0", m3_valid); end
        send(8'h00, 1, 0);
        send(8'h00, 1, 0);
        checks++; if ({m3_valid, m3_locked, m3_data} !== {2'b10, 8'hC1}) begin errors++; $display("FAIL l3_w0: got %h expected %h", {m3_valid, m3_locked, m3_data}, {2'b10, 8'hC1}); end
        send(8'h00, 1, 0);
        checks++; if ({m3_valid, m3_locked, m3_data} !== {2'b11, 8'h00}) begin errors++; $display("FAIL l3_w1: got %h expected %h", {m3_valid, m3_locked, m3_data}, {2'b11, 8'h00}); end
        #2 reset = 1;
        #1;
        checks++; if ({m3_valid, m3_locked, m3_data} !== 10'h000) begin errors++; $display("FAIL l3_async_reset: got %h expected 000", {m3_valid, m3_locked, m3_data}); end
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        checks++; if ({m3_valid, m3_locked, m3_data} !== 10'h000) begin errors++; $display("FAIL l3_after_release: got %h expected 000", {m3_valid, m3_locked, m3_data}); end
        send(8'h01, 1, 0);
        send(8'h00, 1, 0);
        send(8'h00, 1, 0);
        checks++; if ({m3_valid, m3_locked, m3_data} !== {2'b10, 8'hC1}) begin errors++; $display("FAIL l3_relock_w0: got %h expected %h", {m3_valid, m3_locked, m3_data}, {2'b10, 8'hC1}); end
        send(8'h00, 1, 0);
        checks++; if ({m3_valid, m3_locked, m3_data} !== {2'b11, 8'h00}) begin errors++; $display("FAIL l3_relock_w1: got %h expected %h", {m3_valid, m3_locked, m3_data}, {2'b11, 8'h00}); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bubble_cke;
        test_clear;
        test_round_trip;
        test_error_injection;
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
